alu_seq: RTL and testbench

Parametrised multi-cycle successor to the datapath ALU.
- Adds SUB/OR/XOR, iterative shifts and an unsigned shift-add multiply.
- Registers its result and NZP/C/V flags behind a Start/Busy/Done handshake.
- Sits between the register file and the bus mux. The control FSM issues Start and waits for Done before latching the result.

---
 rtl/alu_seq.sv | 218 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative one-bit-per-cycle shifts and
// an unsigned shift-add multiply, with registered result and NZP/C/V flags behind Start/Busy/Done.
module alu_seq #(
   parameter int WIDTH = 16,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [3:0]       Op,
   input  logic [WIDTH-1:0] A_In,
   input  logic [WIDTH-1:0] B_In,
   output logic [WIDTH-1:0] Out,
   output logic             N,
   output logic             Z,
   output logic             P,
   output logic             C,
   output logic             V,
   output logic             Busy,
   output logic             Done
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_NOT = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;
   localparam logic [3:0] OP_SAR = 4'b1010;
   localparam logic [3:0] OP_MUL = 4'b1011;

   localparam logic [SHW-1:0] CNT_ONE = SHW'(1);
   localparam logic [SHW-1:0] CNT_MUL = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      MUL   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           op_q, op_d;
   logic [SHW-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]     sh_q, sh_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [WIDTH-1:0]     out_q, out_d;
   logic                 n_q, n_d, z_q, z_d, p_q, p_d;
   logic                 c_q, c_d, v_q, v_d;
   logic                 done_q, done_d;

   logic                 finish;
   logic [WIDTH-1:0]     res;
   logic                 resC, resV;
   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       mulSum;
   logic [2*WIDTH-1:0]   prodNext;
   logic [WIDTH-1:0]     shNext;
   logic                 shOut;

   // One multiplier bit per step: add the multiplicand into the upper half, then shift right.
   always_comb begin
      mulSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
      prodNext = {mulSum, prod_q[WIDTH-1:1]};
   end

   always_comb begin
      shNext = sh_q;
      shOut  = 1'b0;
      case (op_q)
         OP_SHR:  begin shNext = {1'b0, sh_q[WIDTH-1:1]};        shOut = sh_q[0];       end
         OP_SAR:  begin shNext = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]}; shOut = sh_q[0];     end
         default: begin shNext = {sh_q[WIDTH-2:0], 1'b0};        shOut = sh_q[WIDTH-1]; end
      endcase
   end

   // Next-state logic; any completing path raises finish, and result/flags are committed together.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      out_d   = out_q;
      n_d     = n_q;
      z_d     = z_q;
      p_d     = p_q;
      c_d     = c_q;
      v_d     = v_q;
      done_d  = 1'b0;
      finish  = 1'b0;
      res     = '0;
      resC    = 1'b0;
      resV    = 1'b0;
      sum     = '0;

      case (state_q)
         IDLE: begin
            if (Start) begin
               op_d = Op;
               case (Op)
                  OP_ADD: begin
                     sum    = {1'b0, A_In} + {1'b0, B_In};
                     res    = sum[WIDTH-1:0];
                     resC   = sum[WIDTH];
                     resV   = (A_In[WIDTH-1] == B_In[WIDTH-1]) && (res[WIDTH-1] != A_In[WIDTH-1]);
                     finish = 1'b1;
                  end
                  OP_SUB: begin
                     sum    = {1'b0, A_In} + {1'b0, ~B_In} + (WIDTH+1)'(1);
                     res    = sum[WIDTH-1:0];
                     resC   = sum[WIDTH];
                     resV   = (A_In[WIDTH-1] != B_In[WIDTH-1]) && (res[WIDTH-1] != A_In[WIDTH-1]);
                     finish = 1'b1;
                  end
                  OP_AND: begin res = A_In & B_In; finish = 1'b1; end
                  OP_OR:  begin res = A_In | B_In; finish = 1'b1; end
                  OP_XOR: begin res = A_In ^ B_In; finish = 1'b1; end
                  OP_NOT: begin res = ~A_In;       finish = 1'b1; end
                  OP_SHL, OP_SHR, OP_SAR: begin
                     if (B_In[SHW-1:0] == '0) begin
                        res    = A_In;
                        finish = 1'b1;
                     end else begin
                        sh_d    = A_In;
                        cnt_d   = B_In[SHW-1:0] - CNT_ONE;
                        state_d = SHIFT;
                     end
                  end
                  OP_MUL: begin
                     mcand_d = A_In;
                     prod_d  = {{WIDTH{1'b0}}, B_In};
                     cnt_d   = CNT_MUL;
                     state_d = MUL;
                  end
                  default: begin res = A_In; finish = 1'b1; end
               endcase
            end
         end
         SHIFT: begin
            sh_d  = shNext;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == '0) begin
               res     = shNext;
               resC    = shOut;
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         MUL: begin
            prod_d = prodNext;
            cnt_d  = cnt_q - CNT_ONE;
            if (cnt_q == '0) begin
               res     = prodNext[WIDTH-1:0];
               resC    = |prodNext[2*WIDTH-1:WIDTH];
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (finish) begin
         out_d  = res;
         c_d    = resC;
         v_d    = resV;
         n_d    = res[WIDTH-1];
         z_d    = (res == '0);
         p_d    = !res[WIDTH-1] && (res != '0);
         done_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         sh_q    <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         out_q   <= '0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         p_q     <= 1'b0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         out_q   <= out_d;
         n_q     <= n_d;
         z_q     <= z_d;
         p_q     <= p_d;
         c_q     <= c_d;
         v_q     <= v_d;
         done_q  <= done_d;
      end
   end

   assign Out  = out_q;
   assign N    = n_q;
   assign Z    = z_q;
   assign P    = p_q;
   assign C    = c_q;
   assign V    = v_q;
   assign Done = done_q;
   assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed results, flags and latencies for each op class,
// ignored Start while busy, back-to-back Start, and asynchronous reset mid-multiply.
module tb_alu_seq;

   localparam int WIDTH = 16;

   logic             Clk;
   logic             Reset;
   logic             Start;
   logic [3:0]       Op;
   logic [WIDTH-1:0] A_In;
   logic [WIDTH-1:0] B_In;
   logic [WIDTH-1:0] Out;
   logic             N, Z, P, C, V, Busy, Done;

   int assertCount;
   int failCount;
   int lat;
   int doneSeen;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Start (Start),
      .Op    (Op),
      .A_In  (A_In),
      .B_In  (B_In),
      .Out   (Out),
      .N     (N),
      .Z     (Z),
      .P     (P),
      .C     (C),
      .V     (V),
      .Busy  (Busy),
      .Done  (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Every comparison funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive Start for exactly one rising edge; returns 1ns after that edge.
   task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      @(negedge Clk);
      Start = 1'b1;
      Op    = op;
      A_In  = a;
      B_In  = b;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      Op    = 4'b1111;
      A_In  = 16'hDEAD;
      B_In  = 16'hBEEF;
   endtask

   // Count further edges until Done is seen; a bounded wait so a stuck design still ends.
   task automatic waitDone(output int edges);
      edges = 0;
      while (!Done && edges < 40) begin
         @(posedge Clk);
         #1;
         edges++;
      end
   endtask

   task automatic runCheck(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input int expLat,
                           input logic [WIDTH-1:0] expOut, input logic [4:0] expFlags);
      int l;
      applyStimulus(op, a, b);
      checkOutput({tag, "_busy"}, 32'(Busy), (expLat > 0) ? 32'd1 : 32'd0);
      waitDone(l);
      checkOutput({tag, "_lat"}, 32'(l), 32'(expLat));
      checkOutput({tag, "_out"}, 32'(Out), 32'(expOut));
      checkOutput({tag, "_flags"}, 32'({N, Z, P, C, V}), 32'(expFlags));
      checkOutput({tag, "_busyDone"}, 32'(Busy), 32'd0);
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      Reset = 1'b1;
      Start = 1'b0;
      Op    = 4'b0000;
      A_In  = '0;
      B_In  = '0;
      repeat (2) @(posedge Clk);
      #1;
      checkOutput("reset_out", 32'(Out), 32'h0);
      checkOutput("reset_flags", 32'({N, Z, P, C, V}), 32'h0);
      checkOutput("reset_busyDone", 32'({Busy, Done}), 32'h0);
      @(negedge Clk);
      Reset = 1'b0;

      // Flags are packed {N,Z,P,C,V}.
      runCheck("add_ovf",  4'b0000, 16'h7FFF, 16'h0001, 0,  16'h8000, 5'b10001);
      runCheck("sub_neg",  4'b0100, 16'h0003, 16'h0005, 0,  16'hFFFE, 5'b10000);
      runCheck("sub_pos",  4'b0100, 16'h0005, 16'h0003, 0,  16'h0002, 5'b00110);
      runCheck("sar2",     4'b1010, 16'h8004, 16'h0002, 2,  16'hE001, 5'b10000);
      runCheck("shl0",     4'b1000, 16'h8001, 16'h0000, 0,  16'h8001, 5'b10000);
      runCheck("shl1",     4'b1000, 16'h8001, 16'h0001, 1,  16'h0002, 5'b00110);
      runCheck("shr1",     4'b1001, 16'h8001, 16'h0001, 1,  16'h4000, 5'b00110);
      runCheck("mul_ovf",  4'b1011, 16'h0100, 16'h0101, 16, 16'h0100, 5'b00110);
      runCheck("mul_small",4'b1011, 16'h00FF, 16'h0003, 16, 16'h02FD, 5'b00100);
      runCheck("and",      4'b0001, 16'hF0F0, 16'h0FF0, 0,  16'h00F0, 5'b00100);
      runCheck("or",       4'b0101, 16'h00F0, 16'h0F00, 0,  16'h0FF0, 5'b00100);
      runCheck("xor",      4'b0110, 16'hFFFF, 16'h0001, 0,  16'hFFFE, 5'b10000);
      runCheck("not",      4'b0010, 16'h0000, 16'h1234, 0,  16'hFFFF, 5'b10000);
      runCheck("pass_11xx",4'b1100, 16'h0000, 16'h5555, 0,  16'h0000, 5'b01000);

      // Start with ADD five edges into a MUL must be dropped.
      applyStimulus(4'b1011, 16'h0003, 16'h0005);
      repeat (4) @(posedge Clk);
      applyStimulus(4'b0000, 16'h1111, 16'h2222);
      waitDone(lat);
      checkOutput("ignore_lat", 32'(lat), 32'd11);
      checkOutput("ignore_out", 32'(Out), 32'h000F);
      checkOutput("ignore_flags", 32'({N, Z, P, C, V}), 32'b00100);
      // Start issued during the Done cycle is taken immediately.
      applyStimulus(4'b0000, 16'h0001, 16'hFFFF);
      checkOutput("b2b_done", 32'(Done), 32'd1);
      checkOutput("b2b_out", 32'(Out), 32'h0000);
      checkOutput("b2b_flags", 32'({N, Z, P, C, V}), 32'b01010);
      @(posedge Clk);
      #1;
      checkOutput("done_pulse", 32'(Done), 32'd0);
      checkOutput("hold_out", 32'(Out), 32'h0000);

      // Asynchronous reset in the middle of a multiply.
      applyStimulus(4'b1011, 16'h00FF, 16'h00FF);
      repeat (6) @(posedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("arst_out", 32'(Out), 32'h0);
      checkOutput("arst_flags", 32'({N, Z, P, C, V}), 32'h0);
      checkOutput("arst_busyDone", 32'({Busy, Done}), 32'h0);
      @(negedge Clk);
      Reset = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge Clk);
         #1;
         if (Done) doneSeen++;
      end
      checkOutput("arst_noDone", 32'(doneSeen), 32'd0);
      runCheck("add_zero", 4'b0000, 16'h0000, 16'h0000, 0, 16'h0000, 5'b01000);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
